// File: rtl/wbuf_pkg.sv
// ============================================================================
// Module   : wbuf_pkg
// Purpose  : Shared widths, FSM state encoding and line-tag helper for the
//            line write buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wbuf_pkg;

   localparam int LINE_W   = 128;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 4;
   localparam int TAG_W    = ADDR_W - OFFSET_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_W];
   endfunction

endpackage

`default_nettype wire

// File: rtl/line_write_buffer_if.sv
// ============================================================================
// Module   : line_write_buffer_if
// Purpose  : Cache-side request bus and backing-memory bus of the write buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_write_buffer_if;
   import wbuf_pkg::*;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] data_to_mem;
   logic              mem_ready;
   logic [LINE_W-1:0] data_from_mem;

   logic              dm_read;
   logic              dm_write;
   logic [ADDR_W-1:0] dm_addr;
   logic [LINE_W-1:0] dm_wdata;
   logic              dm_ready;
   logic [LINE_W-1:0] dm_rdata;

   modport slave (
      input  mem_read, mem_write, mem_addr, data_to_mem, dm_ready, dm_rdata,
      output mem_ready, data_from_mem, dm_read, dm_write, dm_addr, dm_wdata
   );

   modport master (
      output mem_read, mem_write, mem_addr, data_to_mem, dm_ready, dm_rdata,
      input  mem_ready, data_from_mem, dm_read, dm_write, dm_addr, dm_wdata
   );

endinterface

`default_nettype wire

// File: rtl/wbuf_store.sv
// ============================================================================
// Module   : wbuf_store
// Purpose  : Circular line FIFO with valid bits, explicit count and a
//            youngest-match line lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbuf_store
   import wbuf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int IW    = $clog2(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              push_i,
   input  wire logic              pop_i,
   input  wire logic              merge_i,
   input  wire logic [IW-1:0]     merge_idx_i,
   input  wire logic [TAG_W-1:0]  tag_i,
   input  wire logic [LINE_W-1:0] data_i,
   output logic                   hit_o,
   output logic [IW-1:0]          hit_idx_o,
   output logic [LINE_W-1:0]      hit_data_o,
   output logic [IW-1:0]          head_idx_o,
   output logic [TAG_W-1:0]       head_tag_o,
   output logic [LINE_W-1:0]      head_data_o,
   output logic                   empty_o,
   output logic                   full_o
);

   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [LINE_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [IW-1:0]     head_q;
   logic [IW-1:0]     tail_q;
   logic [IW:0]       count_q;
   logic [IW-1:0]     scan_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop_i) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         if (push_i) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         count_q <= count_q + {{IW{1'b0}}, push_i} - {{IW{1'b0}}, pop_i};
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         tag_q[tail_q]  <= tag_i;
         data_q[tail_q] <= data_i;
      end
      if (merge_i) begin
         data_q[merge_idx_i] <= data_i;
      end
   end

   // Scan oldest to youngest so a deferred duplicate of the head wins.
   always_comb begin
      hit_o     = 1'b0;
      hit_idx_o = head_q;
      scan_idx  = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + IW'(i);
         if (valid_q[scan_idx] && (tag_q[scan_idx] == tag_i)) begin
            hit_o     = 1'b1;
            hit_idx_o = scan_idx;
         end
      end
   end

   assign hit_data_o  = data_q[hit_idx_o];
   assign head_idx_o  = head_q;
   assign head_tag_o  = tag_q[head_q];
   assign head_data_o = data_q[head_q];
   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == (IW+1)'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/line_write_buffer.sv
// ============================================================================
// Module   : line_write_buffer
// Purpose  : Cache-line write buffer with merge, drain FSM and read path.
//            Read forwarding is enabled by defining LINE_WBUF_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_write_buffer
   import wbuf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int IW    = $clog2(DEPTH)
) (
   input  wire logic            clk,
   input  wire logic            reset,
   line_write_buffer_if.slave   bus
);

   state_t            state_q, state_d;
   logic              mem_ready_q, mem_ready_d;
   logic [LINE_W-1:0] data_from_mem_q, data_from_mem_d;
   logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;

   logic [TAG_W-1:0]  req_tag;
   logic              hit, empty, full;
   logic [IW-1:0]     hit_idx, head_idx;
   logic [LINE_W-1:0] hit_data, head_data;
   logic [TAG_W-1:0]  head_tag;
   logic              wr_req, rd_req, head_busy, do_merge, do_push, do_pop;
   logic              fwd, rd_go;
   logic              unused_addr_lsb;

   assign req_tag         = line_tag(bus.mem_addr);
   assign unused_addr_lsb = ^bus.mem_addr[OFFSET_W-1:0];

   // The completion cycle is a dead cycle: the cache is dropping its request.
   assign wr_req    = bus.mem_write & ~mem_ready_q;
   assign rd_req    = bus.mem_read & ~bus.mem_write & ~mem_ready_q;
   assign head_busy = (state_q == ST_DRAIN) && (hit_idx == head_idx);
   assign do_merge  = wr_req & hit & ~head_busy;
   assign do_push   = wr_req & ~do_merge & ~full;
   assign do_pop    = (state_q == ST_DRAIN) & bus.dm_ready;

`ifdef LINE_WBUF_FORWARD_EN
   assign fwd   = rd_req & hit & (state_q != ST_READ);
   assign rd_go = rd_req & ~hit;
`else
   assign fwd   = 1'b0;
   assign rd_go = rd_req & empty;
`endif

   wbuf_store #(.DEPTH(DEPTH)) u_store (
      .clk         (clk),
      .reset       (reset),
      .push_i      (do_push),
      .pop_i       (do_pop),
      .merge_i     (do_merge),
      .merge_idx_i (hit_idx),
      .tag_i       (req_tag),
      .data_i      (bus.data_to_mem),
      .hit_o       (hit),
      .hit_idx_o   (hit_idx),
      .hit_data_o  (hit_data),
      .head_idx_o  (head_idx),
      .head_tag_o  (head_tag),
      .head_data_o (head_data),
      .empty_o     (empty),
      .full_o      (full)
   );

   always_comb begin
      state_d         = state_q;
      mem_ready_d     = 1'b0;
      data_from_mem_d = data_from_mem_q;
      rd_tag_d        = rd_tag_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_go) begin
               state_d  = ST_READ;
               rd_tag_d = req_tag;
            end else if (!empty) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.dm_ready) state_d = ST_IDLE;
         end
         ST_READ: begin
            if (bus.dm_ready) begin
               state_d         = ST_IDLE;
               mem_ready_d     = 1'b1;
               data_from_mem_d = bus.dm_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (do_merge || do_push) mem_ready_d = 1'b1;
      if (fwd) begin
         mem_ready_d     = 1'b1;
         data_from_mem_d = hit_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         mem_ready_q     <= 1'b0;
         data_from_mem_q <= '0;
         rd_tag_q        <= '0;
      end else begin
         state_q         <= state_d;
         mem_ready_q     <= mem_ready_d;
         data_from_mem_q <= data_from_mem_d;
         rd_tag_q        <= rd_tag_d;
      end
   end

   assign bus.mem_ready     = mem_ready_q;
   assign bus.data_from_mem = data_from_mem_q;
   assign bus.dm_write      = (state_q == ST_DRAIN);
   assign bus.dm_read       = (state_q == ST_READ);

   always_comb begin
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
      if (state_q == ST_DRAIN) begin
         bus.dm_addr  = {head_tag, {OFFSET_W{1'b0}}};
         bus.dm_wdata = head_data;
      end else if (state_q == ST_READ) begin
         bus.dm_addr  = {rd_tag_q, {OFFSET_W{1'b0}}};
      end
   end

endmodule

`default_nettype wire

// File: doc/line_write_buffer.md
LINE_WRITE_BUFFER -- requirements
Module: line_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of 128-bit line entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports mem_read, mem_write  input  1 each  line read/write request from the cache, held until mem_ready.
REQ-005 SHALL have ports mem_addr  input  32  line address, and data_to_mem  input  128  eviction data.
REQ-006 SHALL have ports mem_ready  output  1  one-cycle completion pulse, and data_from_mem  output  128  read line.
REQ-007 SHALL have ports dm_read, dm_write  output  1 each, dm_addr  output  32, dm_wdata  output  128  to backing memory.
REQ-008 SHALL have ports dm_ready  input  1  memory completion pulse, and dm_rdata  input  128.

Function
REQ-009 SHALL treat mem_addr[3:0] as don't-care, compare lines on [31:4] and drive dm_addr[3:0]=0.
REQ-010 SHALL register mem_ready: it is high exactly one cycle after the accepting edge, for one cycle.
REQ-011 SHALL ignore mem_read/mem_write during the cycle mem_ready is high; the cache drops its request in that cycle.
REQ-012 SHALL accept a write when not full: enqueue {addr,data} at the edge, mem_ready next cycle (latency 1).
REQ-013 SHALL merge a write whose line matches a valid entry by overwriting that entry's data, with no new entry and latency 1, even when full.
REQ-014 SHALL, when full and there is no line match, hold mem_ready low until a drain frees an entry; accept at the edge after dm_ready.
REQ-015 SHALL fire with forwarding enabled on a read whose line matches an entry, returning that entry's data on data_from_mem with mem_ready, latency 1, no memory access.
REQ-016 SHALL, on a read miss, issue dm_read with mem_addr, then return dm_rdata with mem_ready in the cycle after dm_ready.
REQ-017 SHALL run an FSM with states IDLE, DRAIN, READ; IDLE->READ on read miss; IDLE->DRAIN if not empty and no read pending; DRAIN->IDLE and READ->IDLE on dm_ready.
REQ-018 SHALL in DRAIN hold dm_write, dm_addr and dm_wdata at the FIFO head until dm_ready, then pop the head.
REQ-019 SHALL give a pending read priority over starting a drain; a drain in progress is never aborted.
REQ-020 SHALL, when a merge targets the head entry during DRAIN, defer the merge until after the pop and enqueue it as a new entry.
REQ-021 SHALL never assert dm_read and dm_write together.
REQ-022 SHALL use wrap-around head/tail pointers with an explicit count for full/empty; a pop and an enqueue in the same edge leave the count unchanged.

Reset
REQ-023 SHALL on reset low, asynchronously: clear all valid bits, pointers and count to 0, FSM to IDLE, mem_ready/dm_read/dm_write to 0, and data_from_mem/dm_addr/dm_wdata to 0.
REQ-024 SHALL abandon any in-flight drain or read on reset mid-operation; buffered lines are lost.

Configuration
REQ-025 SHALL implement read forwarding (REQ-015) only when macro LINE_WBUF_FORWARD_EN is defined.
REQ-026 SHALL, without LINE_WBUF_FORWARD_EN, stall a read (no mem_ready) until the buffer is empty and then serve it from memory per REQ-016.

Structure
REQ-027 SHALL take LINE_W=128, ADDR_W=32, OFFSET_W=4 and the FSM state enum from shared package wbuf_pkg.
REQ-028 SHALL place entry storage, pointers, count and line-match lookup in sub-module wbuf_store; the FSM and handshakes stay in the top.

Verification
REQ-029 SHALL cover: write 0x0000_0010 data A, idle 20 cycles -> mem_ready 1 cycle later; dm_write with addr 0x10 data A; dm_ready -> buffer empty.
REQ-030 SHALL cover: 4 writes to lines 0x00,0x10,0x20,0x30 with dm_ready held low, then a 5th to 0x40 -> no mem_ready until first dm_ready; FIFO order is 0x00 first.
REQ-031 SHALL cover: write 0x20 data B, then write 0x20 data C -> single entry; memory receives C once.
REQ-032 SHALL cover: with LINE_WBUF_FORWARD_EN, write 0x30 data D, read 0x30 -> data_from_mem=D, latency 1, no dm_read; without the macro -> dm_write 0x30 first, then dm_read.
REQ-033 SHALL cover: read miss 0x50 while 2 entries are pending -> dm_read precedes further dm_write; data_from_mem=dm_rdata.
REQ-034 SHALL cover: assert reset during DRAIN -> dm_write drops immediately, count 0, a subsequent read goes to memory.
